vga_frame_scanner: RTL

- Downstream display stage of the asip vector processor.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Scans the processed image out of the processor's synchronous-read output memory and drives the ADV7123-style DAC pins (r, g, b, vsync, hsync, n_sync, n_blanc, n25MHZCLK).
- The image is shown top-left; everything outside it is black.

---
 rtl/vga_frame_scanner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_frame_scanner.sv
// 640x480@60 VGA scanner: paces a 25 MHz pixel grid off the 50 MHz clock, reads
// the processed image from synchronous-read memory and drives the video DAC pins.
module vga_frame_scanner #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hsync,
  output logic              vsync,
  output logic              n_sync,
  output logic              n_blanc,
  output logic              n25MHZCLK,
  output logic              frame_start
);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] HS_FIRST  = 10'd656;
  localparam logic [9:0] HS_LAST   = 10'd751;
  localparam logic [9:0] VS_FIRST  = 10'd490;
  localparam logic [9:0] VS_LAST   = 10'd491;
  localparam logic [9:0] IMG_W_C   = 10'(IMG_W);
  localparam logic [9:0] IMG_H_C   = 10'(IMG_H);
  localparam int         PIX_PAD   = 8 - DATA_W;

  logic              toggle_r;
  logic [9:0]        h_cnt_r;
  logic [9:0]        v_cnt_r;
  logic [9:0]        h_nxt_s;
  logic [9:0]        v_nxt_s;
  logic              wrap_s;
  logic              pix_en_s;
  logic              visible_s;
  logic              hs_n_s;
  logic              vs_n_s;
  logic              in_img_s;
  logic [ADDR_W-1:0] addr_s;
  logic              hs1_r;
  logic              vs1_r;
  logic              vis1_r;
  logic              img1_r;
  logic [7:0]        pixel_s;
  logic [7:0]        colour_s;

  assign pix_en_s  = toggle_r;
  assign n25MHZCLK = toggle_r;
  assign n_sync    = 1'b0;

  // Next raster position; v advances only when h wraps.
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    wrap_s  = 1'b0;
    if (pix_en_s) begin
      if (h_cnt_r == H_LAST) begin
        h_nxt_s = 10'd0;
        if (v_cnt_r == V_LAST) begin
          v_nxt_s = 10'd0;
          wrap_s  = 1'b1;
        end else begin
          v_nxt_s = v_cnt_r + 10'd1;
        end
      end else begin
        h_nxt_s = h_cnt_r + 10'd1;
      end
    end else begin
      h_nxt_s = h_cnt_r;
      v_nxt_s = v_cnt_r;
    end
  end

  // Timing decode and pixel formatting.
  always_comb begin
    visible_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    hs_n_s    = !((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
    vs_n_s    = !((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
    in_img_s  = (h_cnt_r < IMG_W_C) && (v_cnt_r < IMG_H_C);
    addr_s    = ADDR_W'(v_cnt_r) * ADDR_W'(IMG_W) + ADDR_W'(h_cnt_r);
    pixel_s   = 8'(mem_data) << PIX_PAD;
    if (vis1_r && img1_r && disp_en) begin
      colour_s = pixel_s;
    end else begin
      colour_s = 8'd0;
    end
  end

  // Pixel-rate divider and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_r <= 1'b0;
      h_cnt_r  <= 10'd0;
      v_cnt_r  <= 10'd0;
    end else begin
      toggle_r <= ~toggle_r;
      h_cnt_r  <= h_nxt_s;
      v_cnt_r  <= v_nxt_s;
    end
  end

  // Stage 1: issue the read and carry the decode alongside it; the address
  // holds outside the image so it never leaves the memory's range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      hs1_r    <= 1'b1;
      vs1_r    <= 1'b1;
      vis1_r   <= 1'b0;
      img1_r   <= 1'b0;
    end else if (pix_en_s) begin
      if (in_img_s) begin
        mem_addr <= addr_s;
      end else begin
        mem_addr <= mem_addr;
      end
      hs1_r  <= hs_n_s;
      vs1_r  <= vs_n_s;
      vis1_r <= visible_s;
      img1_r <= in_img_s;
    end else begin
      mem_addr <= mem_addr;
    end
  end

  // Stage 2: syncs, blank and colour leave together so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      n_blanc <= 1'b0;
      r       <= 8'd0;
      g       <= 8'd0;
      b       <= 8'd0;
    end else if (pix_en_s) begin
      hsync   <= hs1_r;
      vsync   <= vs1_r;
      n_blanc <= vis1_r;
      r       <= colour_s;
      g       <= colour_s;
      b       <= colour_s;
    end else begin
      hsync   <= hsync;
      vsync   <= vsync;
      n_blanc <= n_blanc;
    end
  end

  // Frame marker: one clk wide, following the raster wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap_s;
    end
  end

endmodule
